// File: rtl/scope_trigger_capture.sv
// Scope trigger/capture: pops ADC samples, arms on a rising edge through
// trig_level, records one screen line and holds it for the VGA renderer.
module scope_trigger_capture #(
  parameter int DEPTH        = 640,
  parameter int AW           = 10,
  parameter int HOLD_FRAMES  = 4,
  parameter int AUTO_TIMEOUT = 1000000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    sample_in,
  input  logic          sample_valid,
  output logic          read_busy,
  input  logic [7:0]    trig_level,
  input  logic          frame_tick,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          capturing,
  output logic          frame_ready,
  output logic          auto_trig
);

  localparam int TW = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
  localparam int HW = $clog2(HOLD_FRAMES + 1);

  localparam logic [TW-1:0] TO_MAX  = TW'(AUTO_TIMEOUT - 1);
  localparam logic [HW-1:0] HF_LAST = HW'(HOLD_FRAMES - 1);
  localparam logic [AW-1:0] W_LAST  = AW'(DEPTH - 1);
  localparam logic [AW:0]   RD_LIM  = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ARMED,
    CAPTURE,
    HOLD
  } state_t;

  state_t        state_q;
  logic [7:0]    prev_q;
  logic          prev_ok_q;
  logic [AW-1:0] waddr_q;
  logic [TW-1:0] tcnt_q;
  logic [HW-1:0] hcnt_q;
  logic          frame_ready_q;
  logic          auto_trig_q;
  logic [7:0]    rd_data_q;

  logic [7:0]    mem [DEPTH];

  logic          accept;
  logic          trig_norm;
  logic          trig_force;
  logic          trig;
  logic          we;
  logic [AW-1:0] wa;
  logic          rd_in_range;

  assign read_busy   = (state_q == HOLD);
  assign capturing   = (state_q == CAPTURE);
  assign frame_ready = frame_ready_q;
  assign auto_trig   = auto_trig_q;
  assign rd_data     = rd_data_q;

  assign accept     = sample_valid & ~read_busy;
  assign trig_norm  = prev_ok_q
                    & (prev_q < trig_level)
                    & (sample_in >= trig_level);
  assign trig_force = (tcnt_q == TO_MAX);
  assign trig       = accept & (state_q == ARMED)
                    & (trig_norm | trig_force);

  // The triggering sample itself lands at address 0.
  assign we = trig | (accept & (state_q == CAPTURE));
  assign wa = trig ? '0 : waddr_q;

  assign rd_in_range = ({1'b0, rd_addr} < RD_LIM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ARMED;
      prev_q        <= '0;
      prev_ok_q     <= 1'b0;
      waddr_q       <= '0;
      tcnt_q        <= '0;
      hcnt_q        <= '0;
      frame_ready_q <= 1'b0;
      auto_trig_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ARMED: begin
          if (tcnt_q != TO_MAX) begin
            tcnt_q <= tcnt_q + TW'(1);
          end
          if (trig) begin
            state_q       <= CAPTURE;
            waddr_q       <= AW'(1);
            frame_ready_q <= 1'b0;
            auto_trig_q   <= ~trig_norm;
            tcnt_q        <= '0;
          end else if (accept) begin
            prev_q    <= sample_in;
            prev_ok_q <= 1'b1;
          end
        end
        CAPTURE: begin
          if (accept) begin
            waddr_q <= waddr_q + AW'(1);
            if (waddr_q == W_LAST) begin
              state_q       <= HOLD;
              frame_ready_q <= 1'b1;
              hcnt_q        <= '0;
            end
          end
        end
        HOLD: begin
          if (frame_tick) begin
            hcnt_q <= hcnt_q + HW'(1);
            if (hcnt_q == HF_LAST) begin
              state_q   <= ARMED;
              prev_ok_q <= 1'b0;
              tcnt_q    <= '0;
            end
          end
        end
        default: state_q <= ARMED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= sample_in;
    end
  end

  // Read-before-write: a same-cycle write is not visible here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_in_range ? mem[rd_addr] : '0;
    end
  end

endmodule
